f_substitute: RTL and testbench
===============================

F_SUBSTITUTE -- requirements
Module: f_substitute

Interface
REQ-001 SHALL have parameter SBOX_PER_CYCLE, default 2: S-boxes evaluated per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: the upstream input is valid.
REQ-005 SHALL have port in_ready, output, 1: the block can accept a new input.
REQ-006 SHALL have port expanded, input, 48: the 48-bit expansion-stage output.
REQ-007 SHALL have port subkey, input, 48: the round subkey.
REQ-008 SHALL have port out_valid, output, 1: f_out is valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts f_out.
REQ-010 SHALL have port f_out, output, 32: the round-function result.
REQ-011 SHALL use this bit mapping on every vector: vector bit i equals DES standard bit i+1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL drive out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready, register x = expanded ^ subkey, clear the group counter and result register, and enter BUSY.
REQ-016 SHALL, in BUSY, on each cycle with counter value c, look up S-boxes j = c*N+1 .. c*N+N (N=SBOX_PER_CYCLE) and write them into the 32-bit S result register.
REQ-017 SHALL use x[6(j-1)+5:6(j-1)] as the input of S-box j.
REQ-018 SHALL form the S-box row from DES bits 1 and 6 of the group and the column from DES bits 2-5, with the first bit as MSB in each case.
REQ-019 SHALL place the 4-bit output of S-box j at result bits [4(j-1)+3:4(j-1)], with DES order MSB-first.
REQ-020 SHALL enter DONE after counter value 8/N-1; latency is exactly 8/N cycles from the accepting edge to out_valid=1 (4 cycles at default).
REQ-021 SHALL drive f_out = P(result register) combinationally, using the FIPS 46-3 P table (f_out bit i = result bit P[i]-1); f_out SHALL be stable throughout DONE.
REQ-022 SHALL, in DONE, hold out_valid and f_out until out_ready=1, then return to IDLE on that edge.
REQ-023 SHALL not accept a new input in the same cycle as the DONE handshake; peak rate is one block per 8/N+2 cycles.
REQ-024 SHALL ignore in_valid in BUSY and DONE; the input is not captured and no error is raised.
REQ-025 SHALL capture expanded/subkey only at acceptance; later changes to these inputs have no effect on the result.
REQ-026 SHALL ignore out_ready outside DONE.

Reset
REQ-027 SHALL, on rst high, go immediately to IDLE, clear x, the counter and the result register, and drive out_valid=0, in_ready=1 and f_out=P(0)=0.
REQ-028 SHALL abort a transaction in BUSY or DONE when reset is asserted and never emit its result.
REQ-029 SHALL allow acceptance on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL keep the following in shared package des_pkg: the 8x64 S-box tables, the 32-entry P table, and the FSM state typedef.
REQ-031 SHALL instantiate sub-module sbox_lookup (combinational; input 6-bit group and box index 1-8; output 4 bits) N times.
REQ-032 SHALL contain no other sub-modules.

Verification
REQ-033 SHALL cover the FIPS round-1 vector: expanded=0x7A15557A1555 and subkey=0x1B02EFFC7072, both in DES order with bit 1 leftmost -> f_out=0x234AA9BB in DES order, with out_valid rising 4 cycles after acceptance.
REQ-034 SHALL cover expanded=0 and subkey=0 -> S output 0xEFA72C4D and f_out=0xD8D8DBBC, both in DES order.
REQ-035 SHALL cover back-pressure: out_ready held 0 for 10 cycles after out_valid -> f_out and out_valid stay stable, in_ready stays 0, and the transaction completes on the first out_ready=1.
REQ-036 SHALL cover in_valid pulsed with new data during BUSY -> it is ignored and the result equals the originally accepted vector.
REQ-037 SHALL cover rst asserted in the second BUSY cycle -> out_valid=0 and in_ready=1 immediately, and the next accepted vector yields a correct result.
REQ-038 SHALL cover SBOX_PER_CYCLE=1 and 8 with the REQ-033 vector -> identical f_out at latency 8 and 1 respectively.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES round-function tables and FSM state type.
package des_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // S-boxes S1..S8; each 256-bit literal lists entries row-major, index {row,col}, leftmost first.
    localparam logic [0:7][0:63][3:0] sbox_tbl = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // FIPS 46-3 P permutation, 1-based source positions
    localparam logic [0:31][5:0] p_tbl = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/sbox_lookup.sv
// One DES S-box lookup; grp[0] is DES bit 1 of the 6-bit group, box is 1..8.
module sbox_lookup
    import des_pkg::*;
(
    input  logic [5:0] grp,
    input  logic [3:0] box,
    output logic [3:0] sout
);

    logic [2:0] box_sel;
    logic [5:0] idx;

    // row = DES bits 1,6; column = DES bits 2..5
    assign box_sel = 3'(box - 4'd1);
    assign idx     = {grp[0], grp[5], grp[1], grp[2], grp[3], grp[4]};
    assign sout    = sbox_tbl[box_sel][idx];

endmodule

// File: rtl/f_substitute.sv
// DES round-function substitution + permutation, SBOX_PER_CYCLE S-boxes per clock.
module f_substitute
    import des_pkg::*;
#(
    parameter int unsigned SBOX_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] expanded,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_out
);

    localparam int unsigned n_groups = 8 / SBOX_PER_CYCLE;
    localparam int unsigned cnt_w    = (n_groups > 1) ? $clog2(n_groups) : 1;

    state_t                               state;
    state_t                               state_nxt;
    logic [47:0]                          x;
    logic [cnt_w-1:0]                     cnt;
    logic [31:0]                          res;
    logic                                 cnt_last;
    logic [SBOX_PER_CYCLE-1:0][3:0]       sout;

    assign cnt_last = (cnt == cnt_w'(n_groups - 1));

    // Group c covers S-boxes c*N+1 .. c*N+N
    for (genvar k = 0; k < SBOX_PER_CYCLE; k++) begin : g_sbox
        logic [5:0] grp;
        logic [3:0] box;

        assign grp = 6'(x >> (6 * (int'(cnt) * SBOX_PER_CYCLE + k)));
        assign box = 4'(int'(cnt) * SBOX_PER_CYCLE + k + 1);

        sbox_lookup u_sbox (
            .grp  (grp),
            .box  (box),
            .sout (sout[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (cnt_last)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            cnt       <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x   <= expanded ^ subkey;
                        cnt <= '0;
                        res <= '0;
                    end
                end
                BUSY: begin
                    for (int unsigned k = 0; k < SBOX_PER_CYCLE; k++) begin
                        res[5'(4 * (int'(cnt) * SBOX_PER_CYCLE + k)) +: 4] <= rev4(sout[k]);
                    end
                    cnt <= cnt_last ? '0 : cnt + cnt_w'(1);
                end
                default: ;
            endcase
        end
    end

    // P permutation is pure wiring off the result register
    always_comb begin
        f_out = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            f_out[i] = res[5'(p_tbl[i] - 6'd1)];
        end
    end

endmodule

// File: tb/tb_f_substitute.sv
// Directed bench for f_substitute at SBOX_PER_CYCLE = 2, 1 and 8.
module tb_f_substitute;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] expanded;
    logic [47:0] subkey;
    logic [2:0]  iv_v;
    logic [2:0]  or_v;
    logic        ir2, ir1, ir8;
    logic        ov2, ov1, ov8;
    logic [31:0] fo2, fo1, fo8;
    logic [2:0]  ir_v;
    logic [2:0]  ov_v;
    logic [31:0] fo_v [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ir_v    = {ir8, ir1, ir2};
    assign ov_v    = {ov8, ov1, ov2};
    assign fo_v[0] = fo2;
    assign fo_v[1] = fo1;
    assign fo_v[2] = fo8;

    f_substitute #(.SBOX_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv_v[0]), .in_ready(ir2),
        .expanded(expanded), .subkey(subkey),
        .out_valid(ov2), .out_ready(or_v[0]), .f_out(fo2)
    );

    f_substitute #(.SBOX_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv_v[1]), .in_ready(ir1),
        .expanded(expanded), .subkey(subkey),
        .out_valid(ov1), .out_ready(or_v[1]), .f_out(fo1)
    );

    f_substitute #(.SBOX_PER_CYCLE(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv_v[2]), .in_ready(ir8),
        .expanded(expanded), .subkey(subkey),
        .out_valid(ov8), .out_ready(or_v[2]), .f_out(fo8)
    );

    // DES-order literals (bit 1 leftmost) map to vector bit 0
    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on dut sel, starting at a negedge and ending at a negedge.
    task automatic xact(input int sel, input logic [47:0] e_des, input logic [47:0] k_des,
                        input logic [31:0] s_des, input logic [31:0] f_des,
                        input int lat_exp, input int bp, input bit poke, input string tag);
        int lat;
        chk({tag, ".idle_ready"}, 64'(ir_v[sel]), 64'd1);
        expanded  = rev48(e_des);
        subkey    = rev48(k_des);
        iv_v[sel] = 1'b1;
        or_v[sel] = 1'b0;
        @(negedge clk);
        iv_v[sel] = 1'b0;
        chk({tag, ".busy_ready"}, 64'(ir_v[sel]), 64'd0);
        lat = 0;
        if (poke) begin
            expanded  = ~expanded;
            subkey    = 48'h0;
            iv_v[sel] = 1'b1;
            @(negedge clk);
            lat       = 1;
            iv_v[sel] = 1'b0;
            expanded  = rev48(48'h123456789ABC);
        end
        while (ov_v[sel] == 1'b0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(lat_exp));
        if (sel == 0) chk({tag, ".sresult"}, 64'(u_dut2.res), 64'(rev32(s_des)));
        for (int i = 0; i < bp; i++) begin
            chk({tag, ".hold_valid"}, 64'(ov_v[sel]), 64'd1);
            chk({tag, ".hold_ready"}, 64'(ir_v[sel]), 64'd0);
            chk({tag, ".hold_fout"}, 64'(fo_v[sel]), 64'(rev32(f_des)));
            @(negedge clk);
        end
        chk({tag, ".fout"}, 64'(fo_v[sel]), 64'(rev32(f_des)));
        // in_valid offered alongside the handshake must not be taken on that edge
        or_v[sel] = 1'b1;
        iv_v[sel] = 1'b1;
        @(negedge clk);
        iv_v[sel] = 1'b0;
        or_v[sel] = 1'b0;
        chk({tag, ".after_valid"}, 64'(ov_v[sel]), 64'd0);
        chk({tag, ".after_ready"}, 64'(ir_v[sel]), 64'd1);
    endtask

    localparam logic [47:0] r1_e = 48'h7A15557A1555;
    localparam logic [47:0] r1_k = 48'h1B02EFFC7072;
    localparam logic [31:0] r1_s = 32'h5C82B597;
    localparam logic [31:0] r1_f = 32'h234AA9BB;
    localparam logic [31:0] z_s  = 32'hEFA72C4D;
    localparam logic [31:0] z_f  = 32'hD8D8DBBC;
    localparam logic [31:0] o_s  = 32'hD9CE3DCB;
    localparam logic [31:0] o_f  = 32'h38DBF9CB;

    initial begin
        rst      = 1'b1;
        iv_v     = '0;
        or_v     = '0;
        expanded = '0;
        subkey   = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset.in_ready", 64'(ir_v[d]), 64'd1);
            chk("reset.out_valid", 64'(ov_v[d]), 64'd0);
            chk("reset.f_out", 64'(fo_v[d]), 64'd0);
        end
        rst = 1'b0;

        xact(0, r1_e, r1_k, r1_s, r1_f, 4, 0, 1'b0, "round1_n2");
        xact(0, 48'h0, 48'h0, z_s, z_f, 4, 0, 1'b0, "zero_n2");
        xact(0, 48'hFFFFFFFFFFFF, 48'h0, o_s, o_f, 4, 10, 1'b0, "ones_bp");
        xact(0, 48'h0, 48'h0, z_s, z_f, 4, 0, 1'b1, "busy_poke");
        xact(1, r1_e, r1_k, r1_s, r1_f, 8, 0, 1'b0, "round1_n1");
        xact(2, r1_e, r1_k, r1_s, r1_f, 1, 2, 1'b0, "round1_n8");

        // Reset during the second BUSY cycle aborts the transaction
        expanded = rev48(48'h0);
        subkey   = rev48(48'h0);
        iv_v[0]  = 1'b1;
        @(negedge clk);
        iv_v[0]  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 64'(ov2), 64'd0);
        chk("abort.in_ready", 64'(ir2), 64'd1);
        chk("abort.f_out", 64'(fo2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        xact(0, r1_e, r1_k, r1_s, r1_f, 4, 0, 1'b0, "post_abort");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d, errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
